// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port memory shared by instruction fetch and datapath load/store.
// Define ARB_STATS_EN to build the saturating grant/conflict counters and their output ports.
module mem_port_arbiter #(
  parameter int AW         = 6,
  parameter int DW         = 16,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 2
) (
  input  logic          clk_main,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_valid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_if_gnt,
  output logic [15:0]   stat_dm_gnt,
  output logic [15:0]   stat_conflict
`endif
);
  localparam int CW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_LD     = CW'(RD_LAT);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          owner_dm_q, owner_dm_d;
  mem_req_t      req_q, req_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          if_gnt_q, if_gnt_d;
  logic          dm_gnt_q, dm_gnt_d;
  logic          if_vld_q, if_vld_d;
  logic          dm_vld_q, dm_vld_d;
  logic          idle, starve, pick_if, pick_dm, last_wait;

  // DM normally wins a tie; once its streak hits the limit a pending fetch goes first.
  assign idle    = (state_q == IDLE);
  assign starve  = (streak_q >= STREAK_LIM);
  assign pick_if = idle & if_req & (~dm_req | starve);
  assign pick_dm = idle & dm_req & ~pick_if;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    owner_dm_d = owner_dm_q;
    req_d      = req_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!if_req || pick_if)
          streak_d = '0;
        else if (pick_dm && !starve)
          streak_d = streak_q + 1'b1;
        if (pick_dm) begin
          req_d.we    = dm_we;
          req_d.addr  = dm_addr;
          req_d.wdata = dm_wdata;
        end else if (pick_if) begin
          req_d.we    = 1'b0;
          req_d.addr  = if_addr;
        end
        if (pick_if || pick_dm) begin
          state_d    = ACCESS;
          owner_dm_d = pick_dm;
          mem_en_d   = 1'b1;
          mem_we_d   = pick_dm & dm_we;
          if_gnt_d   = pick_if;
          dm_gnt_d   = pick_dm;
        end
      end
      ACCESS: begin
        if (req_q.we) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT;
          cnt_d   = LAT_LD;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(1))
          state_d = IDLE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid is registered: raise it on the edge entering the last WAIT cycle.
  assign last_wait = (state_d == WAIT) && (cnt_d == CW'(1));
  assign if_vld_d  = last_wait & ~owner_dm_q;
  assign dm_vld_d  = last_wait & owner_dm_q;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      owner_dm_q <= 1'b0;
      req_q      <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_vld_q   <= 1'b0;
      dm_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      owner_dm_q <= owner_dm_d;
      req_q      <= req_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_vld_q   <= if_vld_d;
      dm_vld_q   <= dm_vld_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign dm_gnt    = dm_gnt_q;
  assign if_valid  = if_vld_q;
  assign dm_valid  = dm_vld_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign busy      = ~idle;

`ifdef ARB_STATS_EN
  logic conflict;
  assign conflict = idle & if_req & dm_req;

  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      stat_if_gnt   <= '0;
      stat_dm_gnt   <= '0;
      stat_conflict <= '0;
    end else begin
      if (pick_if && stat_if_gnt != 16'hFFFF)
        stat_if_gnt <= stat_if_gnt + 16'd1;
      if (pick_dm && stat_dm_gnt != 16'hFFFF)
        stat_dm_gnt <= stat_dm_gnt + 16'd1;
      if (conflict && stat_conflict != 16'hFFFF)
        stat_conflict <= stat_conflict + 16'd1;
    end
  end
`endif

endmodule
